n_clic_vec: RTL and testbench

Parametrised vectored core-local interrupt controller with nested preemption for the Hippomenes core. It latches edge-triggered requests from `VecSize` sources, arbitrates by programmable priority against the current running level, and presents one registered request to the core. On `ack_i` it enters the handler; on `mret_i` it restores the previous level from a hardware level stack of depth `StackDepth`. This block replaces the fixed-width CLIC inside `top_n_clic` and adds configurable vector count, nesting depth and optional tail-chaining.

---
 rtl/n_clic_vec.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_n_clic_vec.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n_clic_vec.sv
// ---------------------------------------------------------------------------
// n_clic_vec : vectored core-local interrupt controller with nested preemption
//
// Latches rising edges on VecSize request lines and arbitrates the pending,
// enabled vectors by programmable priority against the current running level.
// The result is presented to the core as one registered request. An ack enters
// the handler and pushes the running level onto a hardware stack. An mret pops
// the previous level back.
//
// Parameters
//   VecSize    : number of interrupt sources (2..32)
//   PrioWidth  : priority width; level 0 is thread mode and is never taken
//   StackDepth : maximum nesting depth (1..8)
//
// Ports
//   clk          in  : clock, rising edge
//   reset        in  : asynchronous reset, active low
//   irq_i        in  : request lines, rising-edge sensitive
//   csr_we       in  : configuration write strobe
//   csr_addr     in  : vector index for configuration read/write
//   csr_wdata    in  : write data {prio, enable, pend}
//   csr_rdata    out : combinational read of vector csr_addr, same layout
//   take_o       out : registered interrupt request to the core
//   take_id_o    out : winning vector index
//   take_prio_o  out : winning priority
//   ack_i        in  : core enters handler (honoured only while take_o=1)
//   mret_i       in  : core returns from handler
//   level_o      out : current running level
//   depth_o      out : level stack occupancy
//   underflow_o  out : sticky flag, mret seen with an empty stack
//
// Build option
//   N_CLIC_VEC_TAILCHAIN_EN : when defined, ack_i together with mret_i is a
//   tail-chain. The stack is left alone and the running level moves straight
//   to the winner. That winner is arbitrated against the level being restored
//   (the stack top) rather than the level being left. When undefined, ack_i is
//   ignored in any cycle with mret_i=1.
// ---------------------------------------------------------------------------
module n_clic_vec #(
  parameter int VecSize    = 8,
  parameter int PrioWidth  = 3,
  parameter int StackDepth = 4,
  localparam int VecWidth   = $clog2(VecSize),
  localparam int DepthWidth = $clog2(StackDepth + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [VecSize-1:0]     irq_i,
  input  logic                   csr_we,
  input  logic [VecWidth-1:0]    csr_addr,
  input  logic [PrioWidth+1:0]   csr_wdata,
  output logic [PrioWidth+1:0]   csr_rdata,
  output logic                   take_o,
  output logic [VecWidth-1:0]    take_id_o,
  output logic [PrioWidth-1:0]   take_prio_o,
  input  logic                   ack_i,
  input  logic                   mret_i,
  output logic [PrioWidth-1:0]   level_o,
  output logic [DepthWidth-1:0]  depth_o,
  output logic                   underflow_o
);

  localparam int ArbWidth = 1 + VecWidth + PrioWidth;

  // Per-vector configuration and pending state
  logic [VecSize-1:0]                irq_q_r;
  logic [VecSize-1:0]                pend_r, pend_n_s;
  logic [VecSize-1:0]                en_r, en_n_s;
  logic [VecSize-1:0][PrioWidth-1:0] prio_r, prio_n_s;
  logic [VecSize-1:0]                edge_s;

  // Level stack
  logic [StackDepth-1:0][PrioWidth-1:0] stack_r, stack_n_s;
  logic [PrioWidth-1:0]                 level_r, level_n_s;
  logic [DepthWidth-1:0]                depth_r, depth_n_s;
  logic                                 underflow_r, underflow_n_s;

  // Registered request
  logic                 take_r, take_n_s;
  logic [VecWidth-1:0]  take_id_r, take_id_n_s;
  logic [PrioWidth-1:0] take_prio_r, take_prio_n_s;

  // Control
  logic                 csr_hit_s;
  logic                 do_push_s, do_pop_s, do_tail_s;
  logic [VecWidth-1:0]  clr_id_s;
  logic [PrioWidth-1:0] new_level_s;
  logic [VecWidth-1:0]  tail_id_s;
  logic [PrioWidth-1:0] tail_prio_s;
  logic                 tail_valid_s;
  logic [ArbWidth-1:0]  arb_s;

  // Highest priority eligible vector above thresh; ties go to the lowest
  // index because a later vector only wins on a strictly greater priority.
  // Returns {found, id, prio}.
  function automatic logic [ArbWidth-1:0] arbitrate(
    input logic [VecSize-1:0]                pend,
    input logic [VecSize-1:0]                en,
    input logic [VecSize-1:0][PrioWidth-1:0] prio,
    input logic [PrioWidth-1:0]              thresh
  );
    logic                 found;
    logic [VecWidth-1:0]  id;
    logic [PrioWidth-1:0] best;
    found = 1'b0;
    id    = {VecWidth{1'b0}};
    best  = {PrioWidth{1'b0}};
    for (int i = 0; i < VecSize; i++) begin
      if (pend[i] && en[i] && (prio[i] > thresh) &&
          (prio[i] != {PrioWidth{1'b0}}) && (!found || (prio[i] > best))) begin
        found = 1'b1;
        id    = VecWidth'(i);
        best  = prio[i];
      end else begin
        found = found;
      end
    end
    return {found, id, best};
  endfunction

  assign edge_s    = irq_i & ~irq_q_r;
  assign csr_hit_s = csr_we &&
                     ({{(32-VecWidth){1'b0}}, csr_addr} < 32'(VecSize));

`ifdef N_CLIC_VEC_TAILCHAIN_EN
  logic [PrioWidth-1:0] stack_top_s;
  logic [ArbWidth-1:0]  tail_arb_s;

  // Level that an mret this cycle would restore (0 when the stack is empty)
  always_comb begin
    stack_top_s = {PrioWidth{1'b0}};
    for (int j = 0; j < StackDepth; j++) begin
      if (depth_r == DepthWidth'(j + 1)) begin
        stack_top_s = stack_r[j];
      end else begin
        stack_top_s = stack_top_s;
      end
    end
  end

  // Tail-chain winner is judged against the level being returned to
  assign tail_arb_s   = arbitrate(pend_r, en_r, prio_r, stack_top_s);
  assign tail_valid_s = tail_arb_s[ArbWidth-1];
  assign tail_id_s    = tail_arb_s[ArbWidth-2:PrioWidth];
  assign tail_prio_s  = tail_arb_s[PrioWidth-1:0];

  // Decode ack/mret into push, pop or tail-chain
  always_comb begin
    do_tail_s = ack_i && mret_i && tail_valid_s;
    do_push_s = ack_i && take_r && !mret_i &&
                (depth_r != DepthWidth'(StackDepth));
    do_pop_s  = mret_i && !do_tail_s;
  end
`else
  assign tail_valid_s = 1'b0;
  assign tail_id_s    = {VecWidth{1'b0}};
  assign tail_prio_s  = {PrioWidth{1'b0}};

  // Decode ack/mret; an ack alongside an mret is dropped
  always_comb begin
    do_tail_s = 1'b0;
    do_push_s = ack_i && take_r && !mret_i &&
                (depth_r != DepthWidth'(StackDepth));
    do_pop_s  = mret_i;
  end
`endif

  // Select which vector is being entered and at what level
  always_comb begin
    if (do_tail_s) begin
      clr_id_s    = tail_id_s;
      new_level_s = tail_prio_s;
    end else begin
      clr_id_s    = take_id_r;
      new_level_s = take_prio_r;
    end
  end

  // Next-state for pending/config and the level stack
  always_comb begin
    pend_n_s      = pend_r;
    en_n_s        = en_r;
    prio_n_s      = prio_r;
    stack_n_s     = stack_r;
    level_n_s     = level_r;
    depth_n_s     = depth_r;
    underflow_n_s = underflow_r;

    // Ack clear first, then a new edge, then a CSR write: later wins
    if (do_push_s || do_tail_s) begin
      pend_n_s[clr_id_s] = 1'b0;
    end else begin
      pend_n_s = pend_n_s;
    end
    pend_n_s = pend_n_s | edge_s;
    if (csr_hit_s) begin
      pend_n_s[csr_addr] = csr_wdata[0];
      en_n_s[csr_addr]   = csr_wdata[1];
      prio_n_s[csr_addr] = csr_wdata[PrioWidth+1:2];
    end else begin
      pend_n_s = pend_n_s;
    end

    if (do_push_s) begin
      for (int j = 0; j < StackDepth; j++) begin
        if (depth_r == DepthWidth'(j)) begin
          stack_n_s[j] = level_r;
        end else begin
          stack_n_s[j] = stack_r[j];
        end
      end
      depth_n_s = depth_r + DepthWidth'(1);
      level_n_s = new_level_s;
    end else if (do_tail_s) begin
      level_n_s = new_level_s;
    end else if (do_pop_s) begin
      if (depth_r != {DepthWidth{1'b0}}) begin
        for (int j = 0; j < StackDepth; j++) begin
          if (depth_r == DepthWidth'(j + 1)) begin
            level_n_s = stack_r[j];
          end else begin
            level_n_s = level_n_s;
          end
        end
        depth_n_s = depth_r - DepthWidth'(1);
      end else begin
        // Level is already thread mode with an empty stack
        underflow_n_s = 1'b1;
      end
    end else begin
      level_n_s = level_r;
    end
  end

  // Arbitrate on next-state so take_* never lag an ack or config write
  assign arb_s = arbitrate(pend_n_s, en_n_s, prio_n_s, level_n_s);

  // Request is held off while the stack has no room for another push
  always_comb begin
    if (arb_s[ArbWidth-1] && (depth_n_s != DepthWidth'(StackDepth))) begin
      take_n_s      = 1'b1;
      take_id_n_s   = arb_s[ArbWidth-2:PrioWidth];
      take_prio_n_s = arb_s[PrioWidth-1:0];
    end else begin
      take_n_s      = 1'b0;
      take_id_n_s   = {VecWidth{1'b0}};
      take_prio_n_s = {PrioWidth{1'b0}};
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q_r     <= {VecSize{1'b0}};
      pend_r      <= {VecSize{1'b0}};
      en_r        <= {VecSize{1'b0}};
      prio_r      <= {(VecSize*PrioWidth){1'b0}};
      stack_r     <= {(StackDepth*PrioWidth){1'b0}};
      level_r     <= {PrioWidth{1'b0}};
      depth_r     <= {DepthWidth{1'b0}};
      underflow_r <= 1'b0;
      take_r      <= 1'b0;
      take_id_r   <= {VecWidth{1'b0}};
      take_prio_r <= {PrioWidth{1'b0}};
    end else begin
      irq_q_r     <= irq_i;
      pend_r      <= pend_n_s;
      en_r        <= en_n_s;
      prio_r      <= prio_n_s;
      stack_r     <= stack_n_s;
      level_r     <= level_n_s;
      depth_r     <= depth_n_s;
      underflow_r <= underflow_n_s;
      take_r      <= take_n_s;
      take_id_r   <= take_id_n_s;
      take_prio_r <= take_prio_n_s;
    end
  end

  // Configuration read-back; out-of-range indices read as zero
  always_comb begin
    if ({{(32-VecWidth){1'b0}}, csr_addr} < 32'(VecSize)) begin
      csr_rdata = {prio_r[csr_addr], en_r[csr_addr], pend_r[csr_addr]};
    end else begin
      csr_rdata = {(PrioWidth+2){1'b0}};
    end
  end

  assign take_o      = take_r;
  assign take_id_o   = take_id_r;
  assign take_prio_o = take_prio_r;
  assign level_o     = level_r;
  assign depth_o     = depth_r;
  assign underflow_o = underflow_r;

endmodule

// File: tb/tb_n_clic_vec.sv
// ---------------------------------------------------------------------------
// tb_n_clic_vec : directed bench for n_clic_vec (8 vectors, 3-bit priority,
// stack depth 2, default build without tail-chaining). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_n_clic_vec;

  logic       clk;
  logic       reset;
  logic [7:0] irq_i;
  logic       csr_we;
  logic [2:0] csr_addr;
  logic [4:0] csr_wdata;
  logic [4:0] csr_rdata;
  logic       take_o;
  logic [2:0] take_id_o;
  logic [2:0] take_prio_o;
  logic       ack_i;
  logic       mret_i;
  logic [2:0] level_o;
  logic [1:0] depth_o;
  logic       underflow_o;

  int vectors;
  int miscompares;

  n_clic_vec #(
    .VecSize(8),
    .PrioWidth(3),
    .StackDepth(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .irq_i(irq_i),
    .csr_we(csr_we),
    .csr_addr(csr_addr),
    .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .take_o(take_o),
    .take_id_o(take_id_o),
    .take_prio_o(take_prio_o),
    .ack_i(ack_i),
    .mret_i(mret_i),
    .level_o(level_o),
    .depth_o(depth_o),
    .underflow_o(underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [2:0] p,
                           input logic e, input logic pd);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = {p, e, pd};
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic do_mret();
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
  endtask

  task automatic check_take(input string tag, input logic t,
                            input logic [2:0] id, input logic [2:0] pr);
    check_eq({tag, "_take"}, 32'(take_o), 32'(t));
    if (t) begin
      check_eq({tag, "_id"}, 32'(take_id_o), 32'(id));
      check_eq({tag, "_prio"}, 32'(take_prio_o), 32'(pr));
    end
  endtask

  task automatic check_lvl(input string tag, input logic [2:0] lv,
                           input logic [1:0] dp);
    check_eq({tag, "_level"}, 32'(level_o), 32'(lv));
    check_eq({tag, "_depth"}, 32'(depth_o), 32'(dp));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b0;
    irq_i     = 8'h00;
    csr_we    = 1'b0;
    csr_addr  = 3'd0;
    csr_wdata = 5'd0;
    ack_i     = 1'b0;
    mret_i    = 1'b0;

    // Reset state
    #1;
    check_take("rst", 1'b0, 3'd0, 3'd0);
    check_lvl("rst", 3'd0, 2'd0);
    check_eq("rst_uflow", 32'(underflow_o), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_take("post_rst", 1'b0, 3'd0, 3'd0);

    // Basic take and ack
    csr_write(3'd2, 3'd3, 1'b1, 1'b0);
    check_take("cfg2", 1'b0, 3'd0, 3'd0);
    irq_i[2] = 1'b1;
    tick();
    check_take("basic", 1'b1, 3'd2, 3'd3);
    irq_i[2] = 1'b0;
    do_ack();
    check_lvl("basic_ack", 3'd3, 2'd1);
    check_take("basic_ack", 1'b0, 3'd0, 3'd0);
    csr_addr = 3'd2;
    #1;
    check_eq("basic_rd", 32'(csr_rdata), 32'h0E);

    // Preemption and nesting at level 3
    csr_write(3'd5, 3'd5, 1'b1, 1'b0);
    csr_write(3'd1, 3'd2, 1'b1, 1'b0);
    irq_i = 8'b0010_0010;
    tick();
    check_take("nest", 1'b1, 3'd5, 3'd5);
    irq_i = 8'h00;
    do_ack();
    check_lvl("nest_ack", 3'd5, 2'd2);
    check_take("nest_ack", 1'b0, 3'd0, 3'd0);
    do_mret();
    check_lvl("nest_mret1", 3'd3, 2'd1);
    check_take("nest_mret1", 1'b0, 3'd0, 3'd0);
    do_mret();
    check_lvl("nest_mret2", 3'd0, 2'd0);
    check_take("nest_mret2", 1'b1, 3'd1, 3'd2);
    do_ack();
    check_lvl("v1_ack", 3'd2, 2'd1);
    do_mret();
    check_take("v1_done", 1'b0, 3'd0, 3'd0);

    // Tie break and an edge landing in the ack cycle
    csr_write(3'd4, 3'd4, 1'b1, 1'b0);
    csr_write(3'd1, 3'd4, 1'b1, 1'b0);
    irq_i = 8'b0001_0010;
    tick();
    check_take("tie", 1'b1, 3'd1, 3'd4);
    irq_i = 8'h00;
    tick();
    check_take("tie_hold", 1'b1, 3'd1, 3'd4);
    irq_i[1] = 1'b1;
    do_ack();
    irq_i[1] = 1'b0;
    check_lvl("tie_ack", 3'd4, 2'd1);
    check_take("tie_ack", 1'b0, 3'd0, 3'd0);
    csr_addr = 3'd1;
    #1;
    check_eq("edge_vs_ack_rd", 32'(csr_rdata), 32'h13);
    do_mret();
    check_take("retake", 1'b1, 3'd1, 3'd4);
    do_ack();
    check_eq("retake_rd", 32'(csr_rdata), 32'h12);
    csr_write(3'd4, 3'd4, 1'b0, 1'b0);
    do_mret();
    check_take("tie_done", 1'b0, 3'd0, 3'd0);

    // Stack full holds off a prio-7 request; then underflow
    csr_write(3'd6, 3'd3, 1'b1, 1'b0);
    irq_i[6] = 1'b1;
    tick();
    irq_i[6] = 1'b0;
    check_take("full_a", 1'b1, 3'd6, 3'd3);
    do_ack();
    irq_i[5] = 1'b1;
    tick();
    irq_i[5] = 1'b0;
    check_take("full_b", 1'b1, 3'd5, 3'd5);
    do_ack();
    check_lvl("full", 3'd5, 2'd2);
    csr_write(3'd7, 3'd7, 1'b1, 1'b0);
    irq_i[7] = 1'b1;
    tick();
    irq_i[7] = 1'b0;
    check_take("full_hold", 1'b0, 3'd0, 3'd0);
    csr_addr = 3'd7;
    #1;
    check_eq("full_rd", 32'(csr_rdata), 32'h1F);
    do_mret();
    check_lvl("full_mret", 3'd3, 2'd1);
    check_take("full_mret", 1'b1, 3'd7, 3'd7);
    do_ack();
    check_lvl("v7_ack", 3'd7, 2'd2);
    do_mret();
    do_mret();
    check_lvl("unwind", 3'd0, 2'd0);
    check_eq("uflow_pre", 32'(underflow_o), 32'd0);
    do_mret();
    check_eq("uflow", 32'(underflow_o), 32'd1);
    check_lvl("uflow", 3'd0, 2'd0);

    // mret with ack together: ack dropped, vec 3 stays pending
    csr_write(3'd4, 3'd4, 1'b1, 1'b1);
    check_take("tc_setup", 1'b1, 3'd4, 3'd4);
    do_ack();
    check_lvl("tc_lvl4", 3'd4, 2'd1);
    csr_write(3'd3, 3'd2, 1'b1, 1'b1);
    check_take("tc_low", 1'b0, 3'd0, 3'd0);
    ack_i  = 1'b1;
    mret_i = 1'b1;
    tick();
    ack_i  = 1'b0;
    mret_i = 1'b0;
    check_lvl("tc", 3'd0, 2'd0);
    check_take("tc", 1'b1, 3'd3, 3'd2);
    csr_addr = 3'd3;
    #1;
    check_eq("tc_rd", 32'(csr_rdata), 32'h0B);
    check_eq("uflow_sticky", 32'(underflow_o), 32'd1);

    // Asynchronous reset at depth 2
    do_ack();
    csr_write(3'd5, 3'd5, 1'b1, 1'b1);
    do_ack();
    check_lvl("pre_rst", 3'd5, 2'd2);
    #2;
    reset = 1'b0;
    #1;
    check_take("arst", 1'b0, 3'd0, 3'd0);
    check_lvl("arst", 3'd0, 2'd0);
    check_eq("arst_uflow", 32'(underflow_o), 32'd0);
    #2;
    reset = 1'b1;
    tick();
    tick();
    check_take("arst_idle", 1'b0, 3'd0, 3'd0);
    csr_addr = 3'd3;
    #1;
    check_eq("arst_rd", 32'(csr_rdata), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
